// File: rtl/sram_pkg.sv
// sram_pkg: shared types, widths and strobe helper for the external 256Kx16 async SRAM bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;

   // Halfword-address bit 0 selects the low or high half of a 32-bit word.
   localparam logic HW_LO = 1'b0;
   localparam logic HW_HI = 1'b1;

   typedef enum logic [1:0] {IDLE, LO, HI, RESP} sram_state_e;

   // All SRAM-facing controls, registered together so they switch on the same edge.
   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic lb_n;
      logic ub_n;
      logic dq_oe;
   } sram_strb_t;

   localparam sram_strb_t STRB_OFF = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                       lb_n: 1'b1, ub_n: 1'b1, dq_oe: 1'b0};

   // Strobes for the first cycle of a half access. Reads enable both lanes;
   // writes take the lane enables from the two mask bits of that half.
   function automatic sram_strb_t half_strb(input logic wren, input logic [1:0] bmask);
      sram_strb_t s;
      s      = STRB_OFF;
      s.ce_n = 1'b0;
      if (wren) begin
         s.we_n  = 1'b0;
         s.lb_n  = ~bmask[0];
         s.ub_n  = ~bmask[1];
         s.dq_oe = 1'b1;
      end else begin
         s.oe_n = 1'b0;
         s.lb_n = 1'b0;
         s.ub_n = 1'b0;
      end
      return s;
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit LSU request -> two sequenced 16-bit async SRAM accesses (low half, then high half).
// Latency: response pulse 2*WAIT_CYCLES+1 cycles after accept (W+1 for one-half write, 1 for zero-mask write).
// Backpressure: o_req_rdy high only in IDLE; one request in flight, request inputs ignored while busy.
// Ports: i_clk/i_rstn (sync active-low); i_req_* request (vld/rdy, wren, byte addr, wdata, bmask);
//        o_rsp_vld/o_rsp_rdata completion; o_sram_addr, io_sram_dq, o_sram_*_n registered SRAM pins.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_req_vld,
   output logic               o_req_rdy,
   input  logic               i_req_wren,
   input  logic [18:0]        i_req_addr,
   input  logic [31:0]        i_req_wdata,
   input  logic [3:0]         i_req_bmask,
   output logic               o_rsp_vld,
   output logic [31:0]        o_rsp_rdata,
   output logic [SRAM_AW-1:0] o_sram_addr,
   inout  logic [SRAM_DW-1:0] io_sram_dq,
   output logic               o_sram_ce_n,
   output logic               o_sram_oe_n,
   output logic               o_sram_we_n,
   output logic               o_sram_lb_n,
   output logic               o_sram_ub_n
);

   localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0] HOLD = 4'(WAIT_CYCLES - 2);

   sram_state_e          state_q;
   logic [3:0]           cnt_q;
   logic                 rdy_q;
   logic                 rsp_vld_q;
   logic [31:0]          rdata_q;
   logic [SRAM_DW-1:0]   rd_lo_q;
   logic [SRAM_AW-1:0]   sram_addr_q;
   sram_strb_t           strb_q;
   logic [SRAM_DW-1:0]   dq_out_q;
   logic [16:0]          waddr_q;
   logic                 wren_q;
   logic [1:0]           bmask_hi_q;
   logic [SRAM_DW-1:0]   wdata_hi_q;

   // Word-aligned requests: the byte offset bits carry no information.
   logic addr_lsb_unused;
   assign addr_lsb_unused = ^i_req_addr[1:0];

   logic dq_oe;
   assign dq_oe = strb_q.dq_oe;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         rdy_q       <= 1'b1;
         rsp_vld_q   <= 1'b0;
         rdata_q     <= 32'd0;
         rd_lo_q     <= '0;
         sram_addr_q <= '0;
         strb_q      <= STRB_OFF;
         dq_out_q    <= '0;
         waddr_q     <= 17'd0;
         wren_q      <= 1'b0;
         bmask_hi_q  <= 2'b00;
         wdata_hi_q  <= '0;
      end else begin
         rsp_vld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_req_vld) begin
                  waddr_q    <= i_req_addr[18:2];
                  wren_q     <= i_req_wren;
                  bmask_hi_q <= i_req_bmask[3:2];
                  wdata_hi_q <= i_req_wdata[31:16];
                  rdy_q      <= 1'b0;
                  cnt_q      <= 4'd0;
                  if (i_req_wren && i_req_bmask == 4'h0) begin
                     // Nothing to write: complete without touching the SRAM.
                     state_q   <= RESP;
                     rsp_vld_q <= 1'b1;
                  end else if (i_req_wren && i_req_bmask[1:0] == 2'b00) begin
                     state_q     <= HI;
                     sram_addr_q <= {i_req_addr[18:2], HW_HI};
                     strb_q      <= half_strb(1'b1, i_req_bmask[3:2]);
                     dq_out_q    <= i_req_wdata[31:16];
                  end else begin
                     state_q     <= LO;
                     sram_addr_q <= {i_req_addr[18:2], HW_LO};
                     strb_q      <= half_strb(i_req_wren, i_req_bmask[1:0]);
                     dq_out_q    <= i_req_wdata[15:0];
                  end
               end
            end

            LO, HI: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == LAST) begin
                  cnt_q <= 4'd0;
                  // Read data is sampled at the end of the last cycle of each half;
                  // rdata updates only once the whole word is in.
                  if (!wren_q) begin
                     if (state_q == LO) rd_lo_q <= io_sram_dq;
                     else               rdata_q <= {io_sram_dq, rd_lo_q};
                  end
                  if (state_q == LO && !(wren_q && bmask_hi_q == 2'b00)) begin
                     state_q     <= HI;
                     sram_addr_q <= {waddr_q, HW_HI};
                     strb_q      <= half_strb(wren_q, bmask_hi_q);
                     dq_out_q    <= wdata_hi_q;
                  end else begin
                     // Strobes and dq driver drop together; address holds its last value.
                     state_q   <= RESP;
                     rsp_vld_q <= 1'b1;
                     strb_q    <= STRB_OFF;
                  end
               end else if (cnt_q == HOLD) begin
                  // Last cycle of a half is the hold cycle: we_n released, addr/data stable.
                  strb_q.we_n <= 1'b1;
               end
            end

            RESP: begin
               state_q <= IDLE;
               rdy_q   <= 1'b1;
            end

            default: begin
               state_q <= IDLE;
               rdy_q   <= 1'b1;
               strb_q  <= STRB_OFF;
            end
         endcase
      end
   end

   assign io_sram_dq  = dq_oe ? dq_out_q : 'z;

   assign o_req_rdy   = rdy_q;
   assign o_rsp_vld   = rsp_vld_q;
   assign o_rsp_rdata = rdata_q;
   assign o_sram_addr = sram_addr_q;
   assign o_sram_ce_n = strb_q.ce_n;
   assign o_sram_oe_n = strb_q.oe_n;
   assign o_sram_we_n = strb_q.we_n;
   assign o_sram_lb_n = strb_q.lb_n;
   assign o_sram_ub_n = strb_q.ub_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized + directed bench for sram_ctrl against a word/byte-lane memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_ctrl;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_vld = 1'b0;
   logic        req_rdy;
   logic        req_wren = 1'b0;
   logic [18:0] req_addr = 19'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [3:0]  req_bmask = 4'd0;
   logic        rsp_vld;
   logic [31:0] rsp_rdata;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        ce_n, oe_n, we_n, lb_n, ub_n;

   int errors = 0;
   int checks = 0;

   // Physical SRAM device model (halfword array, byte-lane writes).
   logic [15:0] mem [0:262143];
   // Reference: expected 32-bit word contents keyed by word address.
   logic [31:0] ref_mem [int];
   logic [31:0] last_rd = 32'd0;

   // Per-transaction observations filled by do_req.
   int          obs_lat;
   int          obs_lo;
   int          obs_hi;
   int          obs_we;
   int          obs_addr_bad;
   logic [1:0]  obs_lbub_hi;

   always #5 clk = ~clk;

   sram_ctrl #(.WAIT_CYCLES(W)) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_req_vld   (req_vld),
      .o_req_rdy   (req_rdy),
      .i_req_wren  (req_wren),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .i_req_bmask (req_bmask),
      .o_rsp_vld   (rsp_vld),
      .o_rsp_rdata (rsp_rdata),
      .o_sram_addr (sram_addr),
      .io_sram_dq  (sram_dq),
      .o_sram_ce_n (ce_n),
      .o_sram_oe_n (oe_n),
      .o_sram_we_n (we_n),
      .o_sram_lb_n (lb_n),
      .o_sram_ub_n (ub_n)
   );

   assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

   always @(posedge clk) begin
      if (!ce_n && !we_n) begin
         if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
         if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
      end
   end

   // Bus-safety monitor, active for the whole run.
   always @(negedge clk) begin
      checks++;
      if (!oe_n && dut.dq_oe) begin
         errors++;
         $display("FAIL bus_safety: oe_n=%b dq_oe=%b, required never both active", oe_n, dut.dq_oe);
      end
   end

   function automatic logic [31:0] ref_rd(input logic [18:0] a);
      int k;
      k = int'(a[18:2]);
      if (ref_mem.exists(k)) return ref_mem[k];
      return 32'h0;
   endfunction

   function automatic void ref_wr(input logic [18:0] a, input logic [31:0] wd, input logic [3:0] bm);
      logic [31:0] w;
      w = ref_rd(a);
      for (int i = 0; i < 4; i++)
         if (bm[i]) w[8*i +: 8] = wd[8*i +: 8];
      ref_mem[int'(a[18:2])] = w;
   endfunction

   function automatic int halves(input logic wr, input logic [3:0] bm);
      if (!wr) return 2;
      return int'(bm[1:0] != 2'b00) + int'(bm[3:2] != 2'b00);
   endfunction

   function automatic int exp_lat(input logic wr, input logic [3:0] bm);
      return halves(wr, bm) * W + 1;
   endfunction

   // Issue one request and observe it until the response pulse (bounded).
   task automatic do_req(input logic wr, input logic [18:0] a, input logic [31:0] wd, input logic [3:0] bm);
      int n;
      obs_lat = -1; obs_lo = 0; obs_hi = 0; obs_we = 0; obs_addr_bad = 0; obs_lbub_hi = 2'b11;
      @(negedge clk);
      n = 0;
      while (!req_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      req_vld = 1'b1; req_wren = wr; req_addr = a; req_wdata = wd; req_bmask = bm;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         req_vld = 1'b0;
         if (!ce_n) begin
            if (sram_addr[0]) begin
               obs_hi++;
               obs_lbub_hi = {lb_n, ub_n};
            end else begin
               obs_lo++;
            end
            if (sram_addr[17:1] != a[18:2]) obs_addr_bad++;
            if (!we_n) obs_we++;
         end
         if (rsp_vld) begin
            obs_lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", req_rdy); end
      checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld: got %b want 0", rsp_vld); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
      checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
      checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin
         errors++; $display("FAIL reset_strobes: got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); end
      checks++; if (dut.dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe: got %b want 0", dut.dq_oe); end
      rstn = 1'b1;
   endtask

   task automatic test_write_read();
      logic [31:0] exp;
      do_req(1'b1, 19'h00010, 32'hDEADBEEF, 4'hF);
      ref_wr(19'h00010, 32'hDEADBEEF, 4'hF);
      exp = ref_rd(19'h00010);
      checks++; if (obs_lat != exp_lat(1'b1, 4'hF)) begin errors++; $display("FAIL wr_latency: got %0d want %0d", obs_lat, exp_lat(1'b1, 4'hF)); end
      checks++; if (mem[18'h00008] !== exp[15:0]) begin errors++; $display("FAIL wr_mem_lo: got %h want %h", mem[18'h00008], exp[15:0]); end
      checks++; if (mem[18'h00009] !== exp[31:16]) begin errors++; $display("FAIL wr_mem_hi: got %h want %h", mem[18'h00009], exp[31:16]); end
      checks++; if (obs_we != 2 * (W - 1)) begin errors++; $display("FAIL wr_we_cycles: got %0d want %0d", obs_we, 2 * (W - 1)); end
      do_req(1'b0, 19'h00010, 32'h0, 4'h0);
      last_rd = exp;
      checks++; if (obs_lat != exp_lat(1'b0, 4'h0)) begin errors++; $display("FAIL rd_latency: got %0d want %0d", obs_lat, exp_lat(1'b0, 4'h0)); end
      checks++; if (rsp_rdata !== exp) begin errors++; $display("FAIL rd_data: got %h want %h", rsp_rdata, exp); end
      checks++; if (obs_lo != W || obs_hi != W) begin errors++; $display("FAIL rd_halves: got lo=%0d hi=%0d want %0d each", obs_lo, obs_hi, W); end
   endtask

   task automatic test_partial();
      do_req(1'b1, 19'h00020, 32'h11223344, 4'hF);
      ref_wr(19'h00020, 32'h11223344, 4'hF);
      do_req(1'b1, 19'h00020, 32'h00AB0000, 4'b0100);
      ref_wr(19'h00020, 32'h00AB0000, 4'b0100);
      checks++; if (obs_lat != exp_lat(1'b1, 4'b0100)) begin errors++; $display("FAIL part_latency: got %0d want %0d", obs_lat, exp_lat(1'b1, 4'b0100)); end
      checks++; if (obs_lo != 0 || obs_hi != W) begin errors++; $display("FAIL part_halves: got lo=%0d hi=%0d want 0/%0d", obs_lo, obs_hi, W); end
      checks++; if (obs_lbub_hi !== 2'b01) begin errors++; $display("FAIL part_lanes: got lb_n,ub_n=%b want 01", obs_lbub_hi); end
      do_req(1'b0, 19'h00020, 32'h0, 4'h0);
      last_rd = ref_rd(19'h00020);
      checks++; if (rsp_rdata !== last_rd) begin errors++; $display("FAIL part_readback: got %h want %h", rsp_rdata, last_rd); end
   endtask

   task automatic test_zero_mask();
      do_req(1'b1, 19'h00030, $urandom, 4'h0);
      checks++; if (obs_lat != 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", obs_lat); end
      checks++; if (obs_lo + obs_hi != 0) begin errors++; $display("FAIL zero_ce: got %0d active cycles want 0", obs_lo + obs_hi); end
      checks++; if (rsp_rdata !== last_rd) begin errors++; $display("FAIL zero_rdata_hold: got %h want %h", rsp_rdata, last_rd); end
   endtask

   task automatic test_random();
      logic [18:0] a;
      logic [31:0] wd;
      logic [3:0]  bm;
      logic        wr;
      for (int i = 0; i < 16; i++) begin
         a = 19'(32'h40 + 4 * i);
         wd = $urandom;
         do_req(1'b1, a, wd, 4'hF);
         ref_wr(a, wd, 4'hF);
      end
      for (int i = 0; i < 40; i++) begin
         a  = 19'(32'h40 + 4 * $urandom_range(0, 15));
         wd = $urandom;
         bm = 4'($urandom_range(0, 15));
         wr = 1'($urandom_range(0, 1));
         do_req(wr, a, wd, bm);
         checks++; if (obs_lat != exp_lat(wr, bm)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, obs_lat, exp_lat(wr, bm)); end
         checks++; if (obs_addr_bad != 0) begin errors++; $display("FAIL rnd_addr[%0d]: got %0d bad cycles want 0", i, obs_addr_bad); end
         checks++; if (obs_we != (wr ? halves(wr, bm) * (W - 1) : 0)) begin
            errors++; $display("FAIL rnd_we[%0d]: got %0d want %0d", i, obs_we, wr ? halves(wr, bm) * (W - 1) : 0); end
         if (wr) begin
            ref_wr(a, wd, bm);
         end else begin
            last_rd = ref_rd(a);
         end
         checks++; if (rsp_rdata !== last_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rsp_rdata, last_rd); end
      end
   endtask

   task automatic test_back_to_back();
      int          acc[$];
      logic [18:0] acc_addr[$];
      int          rsp_at[$];
      logic [31:0] rsp_dat[$];
      int          n;
      @(negedge clk);
      n = 0;
      while (!req_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         if (rsp_vld) begin
            rsp_at.push_back(c);
            rsp_dat.push_back(rsp_rdata);
         end
         if (acc.size() < 2) begin
            req_vld = 1'b1; req_wren = 1'b0;
            req_addr = 19'(32'h40 + 4 * $urandom_range(0, 15));
            if (req_rdy) begin
               acc.push_back(c);
               acc_addr.push_back(req_addr);
            end
         end else begin
            req_vld = 1'b0;
         end
      end
      req_vld = 1'b0;
      checks++;
      if (acc.size() != 2 || rsp_at.size() != 2) begin
         errors++; $display("FAIL b2b_counts: got accepts=%0d rsps=%0d want 2/2", acc.size(), rsp_at.size());
      end else begin
         checks++; if (acc[1] - acc[0] != 2 * W + 2) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", acc[1] - acc[0], 2 * W + 2); end
         checks++; if (rsp_at[0] - acc[0] != 2 * W + 1) begin errors++; $display("FAIL b2b_rsp_time: got %0d want %0d", rsp_at[0] - acc[0], 2 * W + 1); end
         checks++; if (rsp_dat[0] !== ref_rd(acc_addr[0])) begin errors++; $display("FAIL b2b_data0: got %h want %h", rsp_dat[0], ref_rd(acc_addr[0])); end
         checks++; if (rsp_dat[1] !== ref_rd(acc_addr[1])) begin errors++; $display("FAIL b2b_data1: got %h want %h", rsp_dat[1], ref_rd(acc_addr[1])); end
         last_rd = ref_rd(acc_addr[1]);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int pulses;
      @(negedge clk);
      n = 0;
      while (!req_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      req_vld = 1'b1; req_wren = 1'b1; req_addr = 19'h00100; req_wdata = $urandom; req_bmask = 4'hF;
      pulses = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         req_vld = 1'b0;
         if (rsp_vld) pulses++;
         if (k == 3) rstn = 1'b0;
      end
      @(negedge clk);
      checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin
         errors++; $display("FAIL rmid_strobes: got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); end
      checks++; if (dut.dq_oe !== 1'b0) begin errors++; $display("FAIL rmid_dq_oe: got %b want 0", dut.dq_oe); end
      checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL rmid_rdy: got %b want 1", req_rdy); end
      rstn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (rsp_vld) pulses++;
         @(negedge clk);
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_no_rsp: got %0d pulses want 0", pulses); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", rsp_rdata); end
      do_req(1'b0, 19'h00010, 32'h0, 4'h0);
      checks++; if (obs_lat != exp_lat(1'b0, 4'h0) || rsp_rdata !== ref_rd(19'h00010)) begin
         errors++; $display("FAIL rmid_recover: got lat=%0d data=%h want lat=%0d data=%h",
                            obs_lat, rsp_rdata, exp_lat(1'b0, 4'h0), ref_rd(19'h00010)); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_partial();
      test_zero_mask();
      test_random();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
